// File: rtl/main_fsm_if.sv
// rtl/main_fsm_if.sv - control bundle between the main FSM and the multicycle datapath
//
// Purpose: groups the opcode input and every datapath control output of the
// main control FSM so the FSM and the datapath connect through one port.
//
// Signals:
//   op         7  opcode, instr[6:0], from the instruction register
//   Branch     1  branch-compare cycle (ANDed with Zero outside)
//   PCUpdate   1  unconditional PC write
//   RegWrite   1  register file write enable
//   MemWrite   1  data memory write enable
//   IRWrite    1  instruction register / OldPC load
//   ResultSrc  2  00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA    2  00 PC, 01 OldPC, 10 rd1
//   ALUSrcB    2  00 rd2, 01 ImmExt, 10 constant 4
//   AdrSrc     1  memory address select: 0 PC, 1 Result
//   ALUOp      2  00 add, 01 subtract, 10 decode funct fields
//   InstrDone  1  pulse in the last state of each instruction
//   Illegal    1  sticky unsupported-opcode flag
//   State      4  current state encoding
//
// Modports: master = datapath side (drives op), slave = FSM side.
interface main_fsm_if;
    logic [6:0] op;
    logic       Branch;
    logic       PCUpdate;
    logic       RegWrite;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       AdrSrc;
    logic [1:0] ALUOp;
    logic       InstrDone;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        output op,
        input  Branch, PCUpdate, RegWrite, MemWrite, IRWrite, ResultSrc,
               ALUSrcA, ALUSrcB, AdrSrc, ALUOp, InstrDone, Illegal, State
    );

    modport slave (
        input  op,
        output Branch, PCUpdate, RegWrite, MemWrite, IRWrite, ResultSrc,
               ALUSrcA, ALUSrcB, AdrSrc, ALUOp, InstrDone, Illegal, State
    );
endinterface

// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - multicycle RISC-V main control FSM
//
// Purpose: sequences each instruction through fetch, decode, execute, memory
// and writeback, driving datapath enables, mux selects and the 2-bit ALUOp
// consumed by the ALU decoder. Moore machine: outputs depend on state only.
//
// Parameters:
//   ILLEGAL_HALT  0: unsupported opcode in Decode returns to Fetch
//                 1: unsupported opcode in Decode parks in Halt until reset
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high; forces Fetch and clears Illegal
//   bus    slave modport of main_fsm_if (op in, all controls out)
module main_fsm #(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    main_fsm_if.slave  bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef struct packed {
        logic       branch;
        logic       pc_update;
        logic       reg_write;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       adr_src;
        logic [1:0] alu_op;
        logic       instr_done;
    } ctrl_t;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    ctrl_t  ctrl_q;

    // Control word for a given state; anything not set stays 0 (Halt included).
    function automatic ctrl_t ctrl_for(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_update  = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src    = 1'b1;
                c.mem_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_update = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = 2'b10;
                c.alu_op     = 2'b01;
                c.branch     = 1'b1;
                c.instr_done = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ILLEGAL_HALT ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                if (bus.op == OP_LW)
                    state_d = S_MEMREAD;
                else if (bus.op == OP_SW)
                    state_d = S_MEMWRITE;
                else
                    state_d = S_FETCH;
            end
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECR:   state_d = S_ALUWB;
            S_EXECI:   state_d = S_ALUWB;
            S_JAL:     state_d = S_ALUWB;
            S_HALT:    state_d = S_HALT;
            // MemWB, MemWrite, ALUWB, BEQ and unreachable encodings go to Fetch.
            default:   state_d = S_FETCH;
        endcase
    end

    // Outputs are registered alongside the state by decoding the next state,
    // so they stay a pure function of State with no output glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            ctrl_q    <= ctrl_for(S_FETCH);
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            ctrl_q    <= ctrl_for(state_d);
        end
    end

    assign bus.Branch    = ctrl_q.branch;
    assign bus.PCUpdate  = ctrl_q.pc_update;
    assign bus.RegWrite  = ctrl_q.reg_write;
    assign bus.MemWrite  = ctrl_q.mem_write;
    assign bus.IRWrite   = ctrl_q.ir_write;
    assign bus.ResultSrc = ctrl_q.result_src;
    assign bus.ALUSrcA   = ctrl_q.alu_src_a;
    assign bus.ALUSrcB   = ctrl_q.alu_src_b;
    assign bus.AdrSrc    = ctrl_q.adr_src;
    assign bus.ALUOp     = ctrl_q.alu_op;
    assign bus.InstrDone = ctrl_q.instr_done;
    assign bus.Illegal   = illegal_q;
    assign bus.State     = state_q;

endmodule

// File: doc/main_fsm.md
Name: main_fsm

Overview:
- Multicycle RISC-V main control FSM.
- Sits directly upstream of the ALU decoder: it sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives datapath enables and mux selects, and supplies the 2-bit ALUOp consumed by the ALU decoder.
- Moore machine: every output is a function of the current state only.

Parameters:
- ILLEGAL_HALT, default 0. 0: an unsupported opcode in Decode returns to Fetch (no-op). 1: it enters the Halt state and stays there until reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces state to Fetch and clears Illegal.
- op  in  7  opcode field, instr[6:0], from the instruction register.
- Branch  out  1  branch-compare cycle; combined with Zero externally to form the PC write.
- PCUpdate  out  1  unconditional PC write.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register / OldPC load.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rd1.
- ALUSrcB  out  2  00 rd2, 01 ImmExt, 10 constant 4.
- AdrSrc  out  1  memory address select: 0 PC, 1 Result.
- ALUOp  out  2  to ALU decoder: 00 add, 01 subtract (branch), 10 decode funct fields.
- InstrDone  out  1  one-cycle pulse in the last state of each instruction.
- Illegal  out  1  sticky flag; set on an unsupported opcode in Decode.
- State  out  4  current state encoding, for debug.

Behaviour:
- State encodings: S0 Fetch=0, S1 Decode=1, S2 MemAdr=2, S3 MemRead=3, S4 MemWB=4, S5 MemWrite=5, S6 ExecuteR=6, S7 ALUWB=7, S8 ExecuteI=8, S9 JAL=9, S10 BEQ=10, S11 Halt=11. Encodings 12-15 are unreachable and return to Fetch on the next edge.
- Any output not listed for a state is 0.
- S0 Fetch: IRWrite=1, PCUpdate=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
- S1 Decode: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- S2 MemAdr: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- S3 MemRead: ResultSrc=00, AdrSrc=1.
- S4 MemWB: ResultSrc=01, RegWrite=1, InstrDone=1.
- S5 MemWrite: ResultSrc=00, AdrSrc=1, MemWrite=1, InstrDone=1.
- S6 ExecuteR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- S8 ExecuteI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- S7 ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1.
- S9 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- S10 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, InstrDone=1.
- S11 Halt: all outputs 0 (State=11, Illegal holds 1).
- Transitions from S1, by op:
  - 0000011 lw or 0100011 sw -> S2
  - 0110011 -> S6
  - 0010011 -> S8
  - 1101111 -> S9
  - 1100011 -> S10
  - other -> set Illegal on the same edge; go to S0 if ILLEGAL_HALT=0, S11 if 1.
- Other transitions:
  - S0->S1.
  - S2: op 0000011 -> S3; op 0100011 -> S5; any other op at S2 -> S0.
  - S3->S4, S4->S0, S5->S0.
  - S6->S7, S8->S7, S9->S7, S7->S0, S10->S0.
  - S11->S11 until reset.
- op is sampled only in S1 and S2; op changes in other states have no effect.
- Cycle counts per instruction: lw 5, sw 4, R-type 4, I-type ALU 4, jal 4, beq 3.
- Reset:
  - Asserting reset at any point, including mid-instruction or in Halt, sets state to S0 and Illegal to 0 immediately, without waiting for clk.
  - While reset is high, outputs show the Fetch values.
  - The first rising edge after reset deasserts moves to S1.
- Illegal stays set across the following instructions until reset.

Test Plan:
- Reset then lw (op=0000011): State sequence 0,1,2,3,4,0. In S4, RegWrite=1, ResultSrc=01, InstrDone=1. In S3, AdrSrc=1.
- sw (op=0100011): State sequence 0,1,2,5,0. In S5, MemWrite=1, AdrSrc=1, RegWrite=0.
- R-type (0110011) then I-type (0010011): States 0,1,6,7 then 0,1,8,7. ALUOp=10 in S6 and S8; ALUSrcB=00 in S6 and 01 in S8.
- beq (1100011): States 0,1,10,0; in S10, ALUOp=01 and Branch=1. jal (1101111): States 0,1,9,7,0; in S9, PCUpdate=1, ALUSrcA=01, ALUSrcB=10.
- Unsupported op=1111111 in Decode:
  - ILLEGAL_HALT=0: next state 0, Illegal=1 and stays 1 through a following lw.
  - ILLEGAL_HALT=1: State=11 and remains 11 for 20 cycles, all outputs 0.
- Reset pulsed asynchronously mid-clock while in S3: State=0 and Illegal=0 before the next rising edge. Next edge after reset deasserts -> State=1.
